// File: rtl/id_issue_queue_if.sv
// Handshake bundle between fetch (IF), the decode/issue queue (ID) and execute (EX).
// The slave side is the queue; the master side is whatever surrounds it.
interface id_issue_queue_if #(
   parameter int AOP_W = 12
);
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_pc;
   logic [31:0]      in_inst;

   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_pc;
   logic [31:0]      out_inst;
   logic [31:0]      out_opr1;
   logic [31:0]      out_opr2;
   logic [31:0]      out_offset;
   logic             out_wren;
   logic [4:0]       out_waddr;
   logic [AOP_W-1:0] out_aluop;
   logic             out_inslot;
   logic             out_ri;

   modport master (
      output in_valid, in_pc, in_inst, out_ready,
      input  in_ready, out_valid, out_pc, out_inst, out_opr1, out_opr2, out_offset,
             out_wren, out_waddr, out_aluop, out_inslot, out_ri
   );

   modport slave (
      input  in_valid, in_pc, in_inst, out_ready,
      output in_ready, out_valid, out_pc, out_inst, out_opr1, out_opr2, out_offset,
             out_wren, out_waddr, out_aluop, out_inslot, out_ri
   );
endinterface

// File: rtl/id_issue_queue.sv
// MIPS-subset decode stage with branch resolution, load-use interlock, delay-slot
// tracking and a small FIFO of decoded bundles toward execute.
//
// state | meaning
// IDLE  | next accepted instruction is an ordinary (non delay-slot) instruction
// SLOT  | a branch/jump was just accepted; next accepted instruction is its delay slot
module id_issue_queue #(
   parameter int DEPTH          = 2,
   parameter int AOP_W          = 12,
   parameter bit LOAD_INTERLOCK = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   id_issue_queue_if.slave     bus,
   output logic [4:0]          reg1addr,
   output logic [4:0]          reg2addr,
   input  logic [31:0]         reg1data,
   input  logic [31:0]         reg2data,
   input  logic                ex_load_valid,
   input  logic [4:0]          ex_load_waddr,
   input  logic                flush,
   output logic                br_valid,
   output logic [31:0]         br_target,
   output logic                stall_req
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

   localparam logic [11:0] ALU_ADD  = 12'h001;
   localparam logic [11:0] ALU_SUB  = 12'h002;
   localparam logic [11:0] ALU_SLT  = 12'h004;
   localparam logic [11:0] ALU_SLTU = 12'h008;
   localparam logic [11:0] ALU_AND  = 12'h010;
   localparam logic [11:0] ALU_NOR  = 12'h020;
   localparam logic [11:0] ALU_OR   = 12'h040;
   localparam logic [11:0] ALU_XOR  = 12'h080;
   localparam logic [11:0] ALU_SLL  = 12'h100;
   localparam logic [11:0] ALU_SRL  = 12'h200;
   localparam logic [11:0] ALU_SRA  = 12'h400;
   localparam logic [11:0] ALU_LUI  = 12'h800;

   typedef enum logic {S_IDLE, S_SLOT} state_t;

   typedef struct packed {
      logic [31:0]      pc;
      logic [31:0]      inst;
      logic [31:0]      opr1;
      logic [31:0]      opr2;
      logic [31:0]      offset;
      logic             wren;
      logic [4:0]       waddr;
      logic [AOP_W-1:0] aluop;
      logic             inslot;
      logic             ri;
   } entry_t;

   state_t           state;
   entry_t           mem [DEPTH];
   entry_t           head;
   entry_t           new_entry;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;

   logic [5:0]  op;
   logic [5:0]  funct;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [4:0]  sa;
   logic [15:0] imm;
   logic [31:0] imm_sext;
   logic [31:0] pc_plus4;

   logic [31:0] d_opr1;
   logic [31:0] d_opr2;
   logic [4:0]  d_waddr;
   logic        d_writes;
   logic [11:0] d_aluop;
   logic        d_ri;
   logic        ren1;
   logic        ren2;
   logic        is_br;
   logic        taken;
   logic [31:0] d_target;

   logic hazard;
   logic push;
   logic pop;

   assign op       = bus.in_inst[31:26];
   assign rs       = bus.in_inst[25:21];
   assign rt       = bus.in_inst[20:16];
   assign rd       = bus.in_inst[15:11];
   assign sa       = bus.in_inst[10:6];
   assign funct    = bus.in_inst[5:0];
   assign imm      = bus.in_inst[15:0];
   assign imm_sext = {{16{imm[15]}}, imm};
   assign pc_plus4 = bus.in_pc + 32'd4;

   assign reg1addr = rs;
   assign reg2addr = rt;

   always_comb begin
      d_opr1   = reg1data;
      d_opr2   = reg2data;
      d_waddr  = 5'd0;
      d_writes = 1'b0;
      d_aluop  = 12'h000;
      d_ri     = 1'b0;
      ren1     = 1'b0;
      ren2     = 1'b0;
      is_br    = 1'b0;
      taken    = 1'b0;
      d_target = pc_plus4 + {imm_sext[29:0], 2'b00};
      case (op)
         6'h00: begin
            case (funct)
               6'h00, 6'h02, 6'h03: begin
                  d_opr1   = {27'd0, sa};
                  ren2     = 1'b1;
                  d_waddr  = rd;
                  d_writes = 1'b1;
                  d_aluop  = (funct == 6'h00) ? ALU_SLL : ((funct == 6'h02) ? ALU_SRL : ALU_SRA);
               end
               6'h08: begin
                  ren1     = 1'b1;
                  is_br    = 1'b1;
                  taken    = 1'b1;
                  d_target = reg1data;
               end
               6'h09: begin
                  ren1     = 1'b1;
                  is_br    = 1'b1;
                  taken    = 1'b1;
                  d_target = reg1data;
                  d_opr1   = bus.in_pc;
                  d_opr2   = 32'd8;
                  d_waddr  = rd;
                  d_writes = 1'b1;
                  d_aluop  = ALU_ADD;
               end
               6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: begin
                  ren1     = 1'b1;
                  ren2     = 1'b1;
                  d_waddr  = rd;
                  d_writes = 1'b1;
                  case (funct)
                     6'h21:   d_aluop = ALU_ADD;
                     6'h23:   d_aluop = ALU_SUB;
                     6'h24:   d_aluop = ALU_AND;
                     6'h25:   d_aluop = ALU_OR;
                     6'h26:   d_aluop = ALU_XOR;
                     6'h27:   d_aluop = ALU_NOR;
                     6'h2A:   d_aluop = ALU_SLT;
                     default: d_aluop = ALU_SLTU;
                  endcase
               end
               default: d_ri = 1'b1;
            endcase
         end
         // REGIMM: rt selects bltz (0) or bgez (1)
         6'h01: begin
            if (rt == 5'd0 || rt == 5'd1) begin
               ren1  = 1'b1;
               is_br = 1'b1;
               taken = (rt == 5'd0) ? reg1data[31] : ~reg1data[31];
            end else begin
               d_ri = 1'b1;
            end
         end
         6'h02, 6'h03: begin
            is_br    = 1'b1;
            taken    = 1'b1;
            d_target = {pc_plus4[31:28], bus.in_inst[25:0], 2'b00};
            if (op == 6'h03) begin
               d_opr1   = bus.in_pc;
               d_opr2   = 32'd8;
               d_waddr  = 5'd31;
               d_writes = 1'b1;
               d_aluop  = ALU_ADD;
            end
         end
         6'h04, 6'h05: begin
            ren1  = 1'b1;
            ren2  = 1'b1;
            is_br = 1'b1;
            taken = (op == 6'h04) ? (reg1data == reg2data) : (reg1data != reg2data);
         end
         6'h06, 6'h07: begin
            ren1  = 1'b1;
            is_br = 1'b1;
            taken = (op == 6'h06) ? (reg1data[31] | (reg1data == 32'd0))
                                  : (~reg1data[31] & (reg1data != 32'd0));
         end
         6'h09, 6'h23: begin
            ren1     = 1'b1;
            d_opr2   = imm_sext;
            d_waddr  = rt;
            d_writes = 1'b1;
            d_aluop  = ALU_ADD;
         end
         6'h0D: begin
            ren1     = 1'b1;
            d_opr2   = {16'd0, imm};
            d_waddr  = rt;
            d_writes = 1'b1;
            d_aluop  = ALU_OR;
         end
         6'h0F: begin
            d_opr2   = {imm, 16'd0};
            d_waddr  = rt;
            d_writes = 1'b1;
            d_aluop  = ALU_LUI;
         end
         6'h2B: begin
            ren1    = 1'b1;
            ren2    = 1'b1;
            d_opr2  = imm_sext;
            d_aluop = ALU_ADD;
         end
         default: d_ri = 1'b1;
      endcase
   end

   assign hazard = LOAD_INTERLOCK & ex_load_valid & (ex_load_waddr != 5'd0) &
                   ((ren1 & (rs == ex_load_waddr)) | (ren2 & (rt == ex_load_waddr)));

   assign stall_req     = ~rst & hazard & bus.in_valid;
   assign bus.in_ready  = ~rst & ~flush & ~hazard & ((count < CNT_W'(DEPTH)) | bus.out_ready);
   assign bus.out_valid = (count != '0);

   assign push = bus.in_valid & bus.in_ready;
   assign pop  = bus.out_valid & bus.out_ready & ~flush & ~rst;

   always_comb begin
      new_entry        = '0;
      new_entry.pc     = bus.in_pc;
      new_entry.inst   = bus.in_inst;
      new_entry.opr1   = d_opr1;
      new_entry.opr2   = d_opr2;
      new_entry.offset = imm_sext;
      new_entry.wren   = d_writes & (d_waddr != 5'd0);
      new_entry.waddr  = d_waddr;
      new_entry.aluop  = AOP_W'(d_aluop);
      new_entry.inslot = (state == S_SLOT);
      new_entry.ri     = d_ri;
   end

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= new_entry;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         state     <= S_IDLE;
         br_valid  <= 1'b0;
         br_target <= 32'd0;
      end else if (flush) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         state    <= S_IDLE;
         br_valid <= 1'b0;
      end else begin
         br_valid <= push & is_br & taken;
         if (push & is_br & taken) begin
            br_target <= d_target;
         end
         if (push) begin
            wr_ptr <= ptr_next(wr_ptr);
            state  <= is_br ? S_SLOT : S_IDLE;
         end
         if (pop) begin
            rd_ptr <= ptr_next(rd_ptr);
         end
         if (push & ~pop) begin
            count <= count + 1'b1;
         end else if (~push & pop) begin
            count <= count - 1'b1;
         end
      end
   end

   // Stale storage is masked so an empty queue presents an all-zero bundle.
   assign head = bus.out_valid ? mem[rd_ptr] : '0;

   assign bus.out_pc     = head.pc;
   assign bus.out_inst   = head.inst;
   assign bus.out_opr1   = head.opr1;
   assign bus.out_opr2   = head.opr2;
   assign bus.out_offset = head.offset;
   assign bus.out_wren   = head.wren;
   assign bus.out_waddr  = head.waddr;
   assign bus.out_aluop  = head.aluop;
   assign bus.out_inslot = head.inslot;
   assign bus.out_ri     = head.ri;

endmodule

// File: tb/tb_id_issue_queue.sv
// Directed bench for id_issue_queue: the driver queues hand-computed bundles,
// a negedge monitor compares every bundle the queue hands to execute.
module tb_id_issue_queue;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic [31:0] opr1;
      logic [31:0] opr2;
      logic [31:0] offset;
      logic        wren;
      logic [4:0]  waddr;
      logic [11:0] aluop;
      logic        inslot;
      logic        ri;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  reg1addr;
   logic [4:0]  reg2addr;
   logic [31:0] reg1data;
   logic [31:0] reg2data;
   logic        ex_load_valid;
   logic [4:0]  ex_load_waddr;
   logic        flush;
   logic        br_valid;
   logic [31:0] br_target;
   logic        stall_req;

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];

   id_issue_queue_if #(.AOP_W(12)) bus ();

   id_issue_queue #(.DEPTH(2), .AOP_W(12), .LOAD_INTERLOCK(1'b1)) dut (
      .clk           (clk),
      .rst           (rst),
      .bus           (bus),
      .reg1addr      (reg1addr),
      .reg2addr      (reg2addr),
      .reg1data      (reg1data),
      .reg2data      (reg2data),
      .ex_load_valid (ex_load_valid),
      .ex_load_waddr (ex_load_waddr),
      .flush         (flush),
      .br_valid      (br_valid),
      .br_target     (br_target),
      .stall_req     (stall_req)
   );

   always #5 clk = ~clk;

   function automatic exp_t mk(input logic [31:0] pc, inst, opr1, opr2, offset,
                               input logic wren, input logic [4:0] waddr,
                               input logic [11:0] aluop, input logic inslot, ri);
      exp_t e;
      e.pc = pc; e.inst = inst; e.opr1 = opr1; e.opr2 = opr2; e.offset = offset;
      e.wren = wren; e.waddr = waddr; e.aluop = aluop; e.inslot = inslot; e.ri = ri;
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   // Present one instruction, wait (bounded) for acceptance, then record its bundle.
   task automatic push(input logic [31:0] pc, inst, r1, r2, input exp_t e);
      int n = 0;
      bus.in_valid = 1'b1; bus.in_pc = pc; bus.in_inst = inst;
      reg1data = r1; reg2data = r2;
      #1;
      while (!bus.in_ready && n < 20) begin
         @(posedge clk); #1; n++;
      end
      checks++;
      if (!bus.in_ready) begin
         errors++;
         $display("FAIL push_accept pc=%h got in_ready=0 want 1", pc);
         bus.in_valid = 1'b0;
      end else begin
         exp_q.push_back(e);
         @(posedge clk); #1;
         bus.in_valid = 1'b0;
      end
   endtask

   task automatic drain();
      int n = 0;
      bus.out_ready = 1'b1;
      while (exp_q.size() != 0 && n < 40) begin
         @(posedge clk); n++;
      end
      #1;
      chk("drain_empty", 32'(exp_q.size()), 32'd0);
      chk("drain_out_valid", {31'd0, bus.out_valid}, 32'd0);
   endtask

   // Monitor: a transfer happens at the next posedge when these hold.
   always @(negedge clk) begin
      if (!rst && !flush && bus.out_valid && bus.out_ready) begin
         exp_t got;
         exp_t e;
         got = mk(bus.out_pc, bus.out_inst, bus.out_opr1, bus.out_opr2, bus.out_offset,
                  bus.out_wren, bus.out_waddr, bus.out_aluop, bus.out_inslot, bus.out_ri);
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL out_unexpected pc=%h got extra bundle want none", got.pc);
         end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
               errors++;
               $display("FAIL out_bundle got pc=%h inst=%h o1=%h o2=%h off=%h we=%b wa=%0d op=%h sl=%b ri=%b want pc=%h inst=%h o1=%h o2=%h off=%h we=%b wa=%0d op=%h sl=%b ri=%b",
                        got.pc, got.inst, got.opr1, got.opr2, got.offset, got.wren, got.waddr, got.aluop, got.inslot, got.ri,
                        e.pc, e.inst, e.opr1, e.opr2, e.offset, e.wren, e.waddr, e.aluop, e.inslot, e.ri);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; flush = 1'b0; ex_load_valid = 1'b0; ex_load_waddr = 5'd0;
      reg1data = 32'd0; reg2data = 32'd0;
      bus.in_valid = 1'b0; bus.in_pc = 32'd0; bus.in_inst = 32'd0; bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_br_valid", {31'd0, br_valid}, 32'd0);
      chk("rst_br_target", br_target, 32'd0);
      chk("rst_stall_req", {31'd0, stall_req}, 32'd0);
      chk("rst_out_pc", bus.out_pc, 32'd0);
      chk("rst_out_opr2", bus.out_opr2, 32'd0);
      rst = 1'b0;
      #1;
      chk("ready_after_rst", {31'd0, bus.in_ready}, 32'd1);

      // ALU and immediate forms
      push(32'h100, 32'h00221821, 32'd5, 32'd7,
           mk(32'h100, 32'h00221821, 32'd5, 32'd7, 32'h1821, 1, 5'd3, 12'h001, 0, 0));
      chk("addu_latency", {31'd0, bus.out_valid}, 32'd1);
      push(32'h104, 32'h00A62023, 32'd10, 32'd3,
           mk(32'h104, 32'h00A62023, 32'd10, 32'd3, 32'h2023, 1, 5'd4, 12'h002, 0, 0));
      push(32'h108, 32'h00031100, 32'h99, 32'h11,
           mk(32'h108, 32'h00031100, 32'd4, 32'h11, 32'h1100, 1, 5'd2, 12'h100, 0, 0));
      push(32'h10C, 32'h2425FFFF, 32'h14, 32'd0,
           mk(32'h10C, 32'h2425FFFF, 32'h14, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 5'd5, 12'h001, 0, 0));
      push(32'h110, 32'h34068001, 32'd0, 32'd0,
           mk(32'h110, 32'h34068001, 32'd0, 32'h8001, 32'hFFFF8001, 1, 5'd6, 12'h040, 0, 0));
      push(32'h114, 32'h3C071234, 32'h55, 32'd0,
           mk(32'h114, 32'h3C071234, 32'h55, 32'h12340000, 32'h1234, 1, 5'd7, 12'h800, 0, 0));
      push(32'h118, 32'hAC430008, 32'h40, 32'h77,
           mk(32'h118, 32'hAC430008, 32'h40, 32'd8, 32'd8, 0, 5'd0, 12'h001, 0, 0));

      // taken beq, delay slot nop, then an ordinary instruction
      push(32'h1000, 32'h10220004, 32'd9, 32'd9,
           mk(32'h1000, 32'h10220004, 32'd9, 32'd9, 32'd4, 0, 5'd0, 12'h000, 0, 0));
      chk("beq_br_valid", {31'd0, br_valid}, 32'd1);
      chk("beq_br_target", br_target, 32'h1014);
      push(32'h1004, 32'h00000000, 32'd0, 32'd0,
           mk(32'h1004, 32'h00000000, 32'd0, 32'd0, 32'd0, 0, 5'd0, 12'h100, 1, 0));
      chk("beq_br_one_cycle", {31'd0, br_valid}, 32'd0);
      push(32'h1008, 32'h00221821, 32'd5, 32'd7,
           mk(32'h1008, 32'h00221821, 32'd5, 32'd7, 32'h1821, 1, 5'd3, 12'h001, 0, 0));

      // not-taken bne still opens a delay slot
      push(32'h2000, 32'h1422FFFE, 32'd3, 32'd3,
           mk(32'h2000, 32'h1422FFFE, 32'd3, 32'd3, 32'hFFFFFFFE, 0, 5'd0, 12'h000, 0, 0));
      chk("bne_not_taken", {31'd0, br_valid}, 32'd0);
      push(32'h2004, 32'h00221821, 32'd5, 32'd7,
           mk(32'h2004, 32'h00221821, 32'd5, 32'd7, 32'h1821, 1, 5'd3, 12'h001, 1, 0));

      // j with region bits from pc+4, reserved instruction in its slot
      push(32'h10000004, 32'h08000040, 32'd0, 32'd0,
           mk(32'h10000004, 32'h08000040, 32'd0, 32'd0, 32'h40, 0, 5'd0, 12'h000, 0, 0));
      chk("j_br_target", br_target, 32'h10000100);
      push(32'h10000008, 32'hFC000000, 32'h12, 32'h34,
           mk(32'h10000008, 32'hFC000000, 32'h12, 32'h34, 32'd0, 0, 5'd0, 12'h000, 1, 1));
      drain();

      // load-use interlock
      ex_load_valid = 1'b1; ex_load_waddr = 5'd2;
      bus.in_valid = 1'b1; bus.in_pc = 32'h900; bus.in_inst = 32'h00221821;
      reg1data = 32'd1; reg2data = 32'd2;
      #1;
      chk("reg1addr", {27'd0, reg1addr}, 32'd1);
      chk("reg2addr", {27'd0, reg2addr}, 32'd2);
      chk("hazard_rt_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("hazard_rt_stall", {31'd0, stall_req}, 32'd1);
      @(posedge clk); #1;
      chk("hazard_no_enqueue", {31'd0, bus.out_valid}, 32'd0);
      ex_load_waddr = 5'd1;
      #1;
      chk("hazard_rs_stall", {31'd0, stall_req}, 32'd1);
      ex_load_valid = 1'b0;
      #1;
      chk("hazard_clear_ready", {31'd0, bus.in_ready}, 32'd1);
      chk("hazard_clear_stall", {31'd0, stall_req}, 32'd0);
      exp_q.push_back(mk(32'h900, 32'h00221821, 32'd1, 32'd2, 32'h1821, 1, 5'd3, 12'h001, 0, 0));
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      chk("hazard_then_enqueued", {31'd0, bus.out_valid}, 32'd1);
      // lui does not read rt, so a load into rt is no hazard
      ex_load_valid = 1'b1; ex_load_waddr = 5'd7;
      push(32'h904, 32'h3C071234, 32'd0, 32'd0,
           mk(32'h904, 32'h3C071234, 32'd0, 32'h12340000, 32'h1234, 1, 5'd7, 12'h800, 0, 0));
      ex_load_valid = 1'b0; ex_load_waddr = 5'd0;
      drain();

      // full queue: third blocked, then simultaneous pop+push
      bus.out_ready = 1'b0;
      push(32'h600, 32'h00221821, 32'd5, 32'd7,
           mk(32'h600, 32'h00221821, 32'd5, 32'd7, 32'h1821, 1, 5'd3, 12'h001, 0, 0));
      push(32'h604, 32'h00A62023, 32'd10, 32'd3,
           mk(32'h604, 32'h00A62023, 32'd10, 32'd3, 32'h2023, 1, 5'd4, 12'h002, 0, 0));
      bus.in_valid = 1'b1; bus.in_pc = 32'h608; bus.in_inst = 32'h3C071234;
      reg1data = 32'd0; reg2data = 32'd0;
      #1;
      chk("full_blocked", {31'd0, bus.in_ready}, 32'd0);
      @(posedge clk); #1;
      chk("full_still_blocked", {31'd0, bus.in_ready}, 32'd0);
      chk("full_head_stable", bus.out_pc, 32'h600);
      bus.out_ready = 1'b1;
      #1;
      chk("full_swap_ready", {31'd0, bus.in_ready}, 32'd1);
      exp_q.push_back(mk(32'h608, 32'h3C071234, 32'd0, 32'h12340000, 32'h1234, 1, 5'd7, 12'h800, 0, 0));
      @(posedge clk); #1;
      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      #1;
      chk("swap_count_full", {31'd0, bus.in_ready}, 32'd0);
      chk("swap_head_order", bus.out_pc, 32'h604);
      drain();

      // flush with two queued entries and a jal redirect pending
      bus.out_ready = 1'b0;
      push(32'h700, 32'h00221821, 32'd5, 32'd7,
           mk(32'h700, 32'h00221821, 32'd5, 32'd7, 32'h1821, 1, 5'd3, 12'h001, 0, 0));
      push(32'h5000, 32'h0C000100, 32'd0, 32'd0,
           mk(32'h5000, 32'h0C000100, 32'h5000, 32'd8, 32'h100, 1, 5'd31, 12'h001, 0, 0));
      chk("jal_br_valid", {31'd0, br_valid}, 32'd1);
      chk("jal_br_target", br_target, 32'h400);
      flush = 1'b1;
      #1;
      chk("flush_blocks_accept", {31'd0, bus.in_ready}, 32'd0);
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("flush_br_valid", {31'd0, br_valid}, 32'd0);
      exp_q.delete();
      bus.out_ready = 1'b1;
      push(32'h710, 32'h00221821, 32'd5, 32'd7,
           mk(32'h710, 32'h00221821, 32'd5, 32'd7, 32'h1821, 1, 5'd3, 12'h001, 0, 0));
      drain();

      // reset mid-transfer with a j redirect pending
      bus.out_ready = 1'b0;
      push(32'h800, 32'h08000010, 32'd0, 32'd0,
           mk(32'h800, 32'h08000010, 32'd0, 32'd0, 32'h10, 0, 5'd0, 12'h000, 0, 0));
      chk("rst_mid_br_pending", {31'd0, br_valid}, 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_mid_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_mid_br_valid", {31'd0, br_valid}, 32'd0);
      chk("rst_mid_br_target", br_target, 32'd0);
      rst = 1'b0;
      exp_q.delete();
      #1;
      chk("ready_after_mid_rst", {31'd0, bus.in_ready}, 32'd1);
      bus.out_ready = 1'b1;
      push(32'h804, 32'h00A62023, 32'd10, 32'd3,
           mk(32'h804, 32'h00A62023, 32'd10, 32'd3, 32'h2023, 1, 5'd4, 12'h002, 0, 0));
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
